order_msg_sequencer: RTL and testbench
======================================

Name: order_msg_sequencer

Overview:
- Drains the UDP payload byte FIFO that the RX extractor fills, and assembles fixed-length order records for the order book.
- Controls FIFO reads and validates the opcode byte of each record.
- Presents each valid record on a valid/ready interface.
- Recovers framing on a stall with an inter-byte timeout, and keeps saturating statistics counters.
- Sits between the payload FIFO read port and the order book input.

Parameters:
- MSG_BYTES, 8, bytes per order record; legal range 2..32.
- TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes of a partial record before it is discarded.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ctrl_enable  in  1  when high, new records may be started.
- ctrl_flush  in  1  one-cycle pulse; discards any partial or pending record.
- fifo_dout  in  8  FIFO read data, valid the cycle after fifo_rd_en (standard mode, not FWFT).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe.
- msg_valid  out  1  a record is available on msg_data.
- msg_ready  in  1  the order book accepts the record.
- msg_data  out  MSG_BYTES*8  the record; byte 0 is in the MSBs.
- msg_count  out  CNT_W  records delivered.
- drop_count  out  CNT_W  records dropped for a bad opcode.
- timeout_count  out  CNT_W  partial records discarded on timeout.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Asserting rst_n low clears everything immediately: all outputs 0, state IDLE, req_cnt/rcv_cnt/timer 0, rd_pend 0.
- Internal state:
  - req_cnt: bytes requested for the current record.
  - rcv_cnt: bytes captured for the current record.
  - rd_pend: fifo_rd_en registered by one cycle; when high, fifo_dout is captured this cycle.
- States: IDLE, FILL, CHECK, PRESENT.
- IDLE: if ctrl_enable && !fifo_empty, go to FILL and assert fifo_rd_en this cycle (req_cnt becomes 1).
- FILL:
  - fifo_rd_en = !fifo_empty && req_cnt < MSG_BYTES, so reads are back-to-back.
  - The block never requests more than MSG_BYTES bytes for one record.
  - When rd_pend is high, shift fifo_dout into byte slot rcv_cnt and increment rcv_cnt.
  - When rcv_cnt reaches MSG_BYTES, go to CHECK.
  - ctrl_enable low does not abort a record that has started.
- Timeout (FILL only):
  - The timer clears on every captured byte and increments otherwise.
  - When the timer reaches TIMEOUT_CYCLES with rd_pend low, discard the partial record, increment timeout_count, clear the counters and go to IDLE.
- CHECK (one cycle):
  - If byte 0 is 0x01 (add), 0x02 (cancel) or 0x03 (modify), go to PRESENT and assert msg_valid.
  - Otherwise increment drop_count and go to IDLE.
- PRESENT:
  - msg_valid stays high and msg_data stays stable until msg_ready.
  - No FIFO reads occur in this state.
  - On the msg_valid && msg_ready cycle: increment msg_count, drop msg_valid the next cycle, go to IDLE.
- Latency: with the FIFO holding at least MSG_BYTES bytes and msg_ready high, reads occur in cycles 0..MSG_BYTES-1. CHECK is cycle MSG_BYTES+1, msg_valid is high in cycle MSG_BYTES+2, and the next record's first read is cycle MSG_BYTES+3.
- ctrl_flush has priority over every other event in the same cycle:
  - Go to IDLE, deassert msg_valid, deassert fifo_rd_en and clear counts.
  - A byte returning the cycle after the flush (rd_pend) is discarded.
  - Counters are not cleared and are not incremented by a flush.
- Statistics counters saturate at all-ones and never wrap.
- fifo_empty rising mid-record pauses reads with no loss. Only the timeout ends the record.
- msg_data is undefined-but-stable outside PRESENT; it is 0 after reset.

Test Plan:
1. Preload the FIFO with 01 00 00 27 10 00 64 AA, msg_ready=1 → fifo_rd_en high for cycles 0..7; msg_valid high in cycle 10 with msg_data=0x0100002710006 4AA; msg_count=1.
2. Preload 16 bytes, both records with opcode 0x02, msg_ready held low 20 cycles → msg_valid held and msg_data stable; exactly 8 reads before the handshake, then the second record follows; msg_count=2.
3. Record with byte 0 = 0x7F, then a valid 0x01 record → drop_count=1, only the second record presented, msg_count=1.
4. Supply 3 bytes then hold the FIFO empty 1100 cycles, TIMEOUT_CYCLES=1024 → timeout_count=1, state IDLE; a following full 0x03 record is delivered intact.
5. Pulse ctrl_flush the cycle after the 4th read → returning byte discarded, state IDLE, no counter change; a subsequent 8-byte record frames correctly.
6. Drop rst_n asynchronously mid-PRESENT → msg_valid, fifo_rd_en, busy and all counters go to 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/order_msg_sequencer.sv
// Drains the payload byte FIFO into fixed-length order records, validates the
// opcode byte and presents good records on a valid/ready interface.
module order_msg_sequencer #(
    parameter int MSG_BYTES      = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ctrl_enable,
    input  logic                   ctrl_flush,
    input  logic [7:0]             fifo_dout,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [MSG_BYTES*8-1:0] msg_data,
    output logic [CNT_W-1:0]       msg_count,
    output logic [CNT_W-1:0]       drop_count,
    output logic [CNT_W-1:0]       timeout_count,
    output logic                   busy
);

    localparam int W  = MSG_BYTES * 8;
    localparam int CW = $clog2(MSG_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(MSG_BYTES - 1);
    localparam logic [CW-1:0] ALL_BYTES = CW'(MSG_BYTES);
    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CHECK,
        PRESENT
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     req_cnt_q, req_cnt_d;
    logic [CW-1:0]     rcv_cnt_q, rcv_cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              rd_pend_q, rd_pend_d;
    logic [W-1:0]      asm_q, asm_d;
    logic [W-1:0]      msg_data_q, msg_data_d;
    logic              msg_valid_q, msg_valid_d;
    logic [CNT_W-1:0]  msg_count_q, msg_count_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;
    logic [CNT_W-1:0]  timeout_count_q, timeout_count_d;
    logic              rd_en;
    logic [7:0]        opcode;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign opcode = asm_q[W-1 -: 8];

    always_comb begin
        state_d         = state_q;
        req_cnt_d       = req_cnt_q;
        rcv_cnt_d       = rcv_cnt_q;
        timer_d         = timer_q;
        asm_d           = asm_q;
        msg_data_d      = msg_data_q;
        msg_valid_d     = msg_valid_q;
        msg_count_d     = msg_count_q;
        drop_count_d    = drop_count_q;
        timeout_count_d = timeout_count_q;
        rd_en           = 1'b0;

        case (state_q)
            IDLE: begin
                if (ctrl_enable && !fifo_empty) begin
                    rd_en     = 1'b1;
                    state_d   = FILL;
                    req_cnt_d = CW'(1);
                    rcv_cnt_d = '0;
                    timer_d   = '0;
                end
            end
            FILL: begin
                rd_en = !fifo_empty && (req_cnt_q < ALL_BYTES);
                if (rd_en) begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                // Bytes arrive one cycle after their read strobe; byte 0 ends up in the MSBs.
                if (rd_pend_q) begin
                    asm_d     = {asm_q[W-9:0], fifo_dout};
                    rcv_cnt_d = rcv_cnt_q + 1'b1;
                    timer_d   = '0;
                    if (rcv_cnt_q == LAST_BYTE) begin
                        state_d = CHECK;
                    end
                end else if (timer_q == TIMEOUT_T) begin
                    rd_en           = 1'b0;
                    state_d         = IDLE;
                    req_cnt_d       = '0;
                    rcv_cnt_d       = '0;
                    timer_d         = '0;
                    timeout_count_d = sat_inc(timeout_count_q);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK: begin
                state_d   = IDLE;
                req_cnt_d = '0;
                rcv_cnt_d = '0;
                if (opcode == 8'h01 || opcode == 8'h02 || opcode == 8'h03) begin
                    msg_data_d  = asm_q;
                    msg_valid_d = 1'b1;
                    state_d     = PRESENT;
                end else begin
                    drop_count_d = sat_inc(drop_count_q);
                end
            end
            PRESENT: begin
                if (msg_ready) begin
                    msg_valid_d = 1'b0;
                    msg_count_d = sat_inc(msg_count_q);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush overrides everything above, including any counter update this cycle.
        if (ctrl_flush) begin
            state_d         = IDLE;
            rd_en           = 1'b0;
            msg_valid_d     = 1'b0;
            req_cnt_d       = '0;
            rcv_cnt_d       = '0;
            timer_d         = '0;
            asm_d           = asm_q;
            msg_count_d     = msg_count_q;
            drop_count_d    = drop_count_q;
            timeout_count_d = timeout_count_q;
        end

        rd_pend_d = rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            req_cnt_q       <= '0;
            rcv_cnt_q       <= '0;
            timer_q         <= '0;
            rd_pend_q       <= 1'b0;
            asm_q           <= '0;
            msg_data_q      <= '0;
            msg_valid_q     <= 1'b0;
            msg_count_q     <= '0;
            drop_count_q    <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            req_cnt_q       <= req_cnt_d;
            rcv_cnt_q       <= rcv_cnt_d;
            timer_q         <= timer_d;
            rd_pend_q       <= rd_pend_d;
            asm_q           <= asm_d;
            msg_data_q      <= msg_data_d;
            msg_valid_q     <= msg_valid_d;
            msg_count_q     <= msg_count_d;
            drop_count_q    <= drop_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    // The read strobe is combinational from IDLE, so it is gated to stay low during reset.
    assign fifo_rd_en    = rd_en & rst_n;
    assign msg_valid     = msg_valid_q;
    assign msg_data      = msg_data_q;
    assign msg_count     = msg_count_q;
    assign drop_count    = drop_count_q;
    assign timeout_count = timeout_count_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_order_msg_sequencer.sv
// Self-checking bench for order_msg_sequencer: a byte-FIFO model feeds the DUT and
// a record-level model (queue of expected records plus counters) predicts its output.
module tb_order_msg_sequencer;

    localparam int MSG_BYTES      = 8;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam int CNT_W          = 4;
    localparam int CNT_MAX        = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   ctrl_enable;
    logic                   ctrl_flush;
    logic [7:0]             fifo_dout = 8'h00;
    logic                   fifo_empty;
    logic                   fifo_rd_en;
    logic                   msg_valid;
    logic                   msg_ready;
    logic [MSG_BYTES*8-1:0] msg_data;
    logic [CNT_W-1:0]       msg_count;
    logic [CNT_W-1:0]       drop_count;
    logic [CNT_W-1:0]       timeout_count;
    logic                   busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  mem [0:1023];
    int          push_cnt = 0;
    int          pop_cnt  = 0;
    logic        rd_take  = 1'b0;
    int          rd_total = 0;
    logic [63:0] exp_q [$];
    int          exp_msg  = 0;
    int          exp_drop = 0;
    int          exp_to   = 0;
    logic        held      = 1'b0;
    logic [63:0] held_data = '0;

    order_msg_sequencer #(
        .MSG_BYTES(MSG_BYTES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ctrl_enable(ctrl_enable),
        .ctrl_flush(ctrl_flush),
        .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .msg_valid(msg_valid),
        .msg_ready(msg_ready),
        .msg_data(msg_data),
        .msg_count(msg_count),
        .drop_count(drop_count),
        .timeout_count(timeout_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Standard-mode FIFO: data appears on fifo_dout the cycle after a read strobe.
    assign fifo_empty = (push_cnt == pop_cnt);

    always @(negedge clk) rd_take = fifo_rd_en && !fifo_empty;

    always @(posedge clk) begin
        if (rd_take) begin
            fifo_dout <= mem[pop_cnt[9:0]];
            pop_cnt   <= pop_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Every handshake must deliver the oldest predicted record; held records stay still.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (fifo_rd_en) rd_total++;
            if (msg_valid) begin
                checkOutput("no_read_in_present", 64'(fifo_rd_en), 64'(0));
                if (held) checkOutput("data_stable", msg_data, held_data);
                if (msg_ready) begin
                    checkOutput("msg_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) checkOutput("msg_data", msg_data, exp_q.pop_front());
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = msg_data;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic rdy, input logic fl);
        ctrl_enable = en;
        msg_ready   = rdy;
        ctrl_flush  = fl;
    endtask

    task automatic pushByte(input logic [7:0] b);
        mem[push_cnt[9:0]] = b;
        push_cnt++;
    endtask

    task automatic modelRecord(input logic [63:0] rec);
        if (rec[63:56] >= 8'h01 && rec[63:56] <= 8'h03) begin
            exp_q.push_back(rec);
            if (exp_msg < CNT_MAX) exp_msg++;
        end else begin
            if (exp_drop < CNT_MAX) exp_drop++;
        end
    endtask

    task automatic pushRecord(input logic [63:0] rec);
        modelRecord(rec);
        for (int b = 0; b < MSG_BYTES; b++) pushByte(rec[63-8*b -: 8]);
    endtask

    task automatic waitValid(input int limit);
        int n = 0;
        @(negedge clk);
        while (!msg_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_valid", 64'(msg_valid), 64'(1));
    endtask

    task automatic waitDrained(input int limit);
        int  n = 0;
        logic done;
        @(negedge clk);
        done = !busy && (push_cnt == pop_cnt) && (exp_q.size() == 0);
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
            done = !busy && (push_cnt == pop_cnt) && (exp_q.size() == 0);
        end
        checkOutput("drain", 64'(done), 64'(1));
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_msg_count"}, 64'(msg_count), 64'(exp_msg));
        checkOutput({tag, "_drop_count"}, 64'(drop_count), 64'(exp_drop));
        checkOutput({tag, "_timeout_count"}, 64'(timeout_count), 64'(exp_to));
    endtask

    initial begin
        logic [63:0] rec;
        int          base;

        rst_n = 1'b0;
        applyStimulus(0, 0, 0);
        repeat (3) tick();
        @(negedge clk);
        checkOutput("rst_msg_valid", 64'(msg_valid), 64'(0));
        checkOutput("rst_rd_en", 64'(fifo_rd_en), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_msg_data", msg_data, 64'(0));
        checkCounters("rst");
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] single record latency");
        pushRecord(64'h01000027100064AA);
        applyStimulus(1, 1, 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t1_rd_en_c%0d", c), 64'(fifo_rd_en), 64'(c < 8));
            checkOutput($sformatf("t1_valid_c%0d", c), 64'(msg_valid), 64'(c == 10));
            if (c == 10) checkOutput("t1_msg_data", msg_data, 64'h01000027100064AA);
            tick();
        end
        @(negedge clk);
        checkCounters("t1");

        $display("[TB] back-pressure on two records");
        tick();
        applyStimulus(1, 0, 0);
        base = rd_total;
        pushRecord({8'h02, 56'h11223344556677});
        pushRecord({8'h02, 56'h8899AABBCCDDEE});
        waitValid(40);
        checkOutput("t2_reads_at_valid", 64'(rd_total - base), 64'(8));
        repeat (20) tick();
        @(negedge clk);
        checkOutput("t2_valid_held", 64'(msg_valid), 64'(1));
        checkOutput("t2_reads_held", 64'(rd_total - base), 64'(8));
        tick();
        applyStimulus(1, 1, 0);
        waitDrained(100);
        checkCounters("t2");

        $display("[TB] bad opcode then good record");
        tick();
        pushRecord({8'h7F, 56'h01020304050607});
        pushRecord({8'h01, 56'hA1A2A3A4A5A6A7});
        waitDrained(100);
        checkCounters("t3");

        $display("[TB] partial record timeout");
        tick();
        pushByte(8'h01);
        pushByte(8'hAA);
        pushByte(8'hBB);
        repeat (1000) tick();
        @(negedge clk);
        checkOutput("t4_busy_before", 64'(busy), 64'(1));
        checkOutput("t4_timeout_before", 64'(timeout_count), 64'(exp_to));
        repeat (100) tick();
        @(negedge clk);
        exp_to++;
        checkOutput("t4_busy_after", 64'(busy), 64'(0));
        checkCounters("t4");
        tick();
        pushRecord({8'h03, 56'h0F1E2D3C4B5A69});
        waitDrained(100);
        checkCounters("t4_next");

        $display("[TB] flush mid-record");
        tick();
        applyStimulus(0, 1, 0);
        pushByte(8'h02); pushByte(8'h11); pushByte(8'h22);
        pushByte(8'h33); pushByte(8'h01); pushByte(8'h55);
        tick();
        applyStimulus(1, 1, 0);
        repeat (4) tick();
        applyStimulus(0, 1, 1);
        @(negedge clk);
        checkOutput("t5_rd_en_flush", 64'(fifo_rd_en), 64'(0));
        tick();
        applyStimulus(0, 1, 0);
        @(negedge clk);
        checkOutput("t5_busy_after", 64'(busy), 64'(0));
        checkCounters("t5");
        tick();
        exp_q.push_back(64'h0155ABCDEF123456);
        if (exp_msg < CNT_MAX) exp_msg++;
        pushByte(8'hAB); pushByte(8'hCD); pushByte(8'hEF);
        pushByte(8'h12); pushByte(8'h34); pushByte(8'h56);
        applyStimulus(1, 1, 0);
        waitDrained(100);
        checkCounters("t5_next");

        $display("[TB] randomized records");
        tick();
        for (int r = 0; r < 24; r++) begin
            rec = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rec[63:56] = 8'($urandom_range(4, 255));
            else rec[63:56] = 8'($urandom_range(1, 3));
            modelRecord(rec);
            for (int b = 0; b < MSG_BYTES; b++) begin
                pushByte(rec[63-8*b -: 8]);
                applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 0);
                tick();
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        applyStimulus(1, 1, 0);
        waitDrained(600);
        checkCounters("rand");

        $display("[TB] asynchronous reset mid-present");
        tick();
        applyStimulus(1, 0, 0);
        pushRecord({8'h02, 56'h5566778899AABB});
        pushByte(8'h01);
        pushByte(8'h02);
        waitValid(40);
        #2;
        rst_n = 1'b0;
        #1;
        exp_msg  = 0;
        exp_drop = 0;
        exp_to   = 0;
        checkOutput("areset_msg_valid", 64'(msg_valid), 64'(0));
        checkOutput("areset_rd_en", 64'(fifo_rd_en), 64'(0));
        checkOutput("areset_busy", 64'(busy), 64'(0));
        checkOutput("areset_msg_data", msg_data, 64'(0));
        checkCounters("areset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
